// File: rtl/pmpd_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pmpd_frame_scheduler
// Brief    : Buffers SPI frames and sequences per-channel sample strobes on a
//            10 Hz tick, with a tick-based link watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module pmpd_frame_scheduler #(
    parameter int TIMEOUT_TICKS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [63:0] rx_data,
    input  logic        tick_10hz,
    input  logic        check_busy,
    output logic [31:0] state_buffer,
    output logic [3:0]  sample_strobe,
    output logic        link_ok,
    output logic [7:0]  frame_err_cnt,
    output logic [7:0]  overrun_cnt
);

    localparam logic [3:0] c_TIMEOUT = 4'(TIMEOUT_TICKS);
    localparam logic [3:0] c_TIMEOUT_M1 = 4'(TIMEOUT_TICKS - 1);
    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMMIT  = 3'd1,
        S_PEDAL = 3'd2,
        S_EXPR  = 3'd3,
        S_BPM   = 3'd4,
        S_RR    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  w_strobe;

    logic [31:0] r_pending;
    logic        r_pending_valid;
    logic [31:0] r_state_buffer;
    logic [3:0]  r_watchdog;
    logic [7:0]  r_frame_err_cnt;
    logic [7:0]  r_overrun_cnt;

    logic        w_accept;
    logic        w_reject;
    logic        w_consume;
    logic        w_expire;
    logic        w_link_ok;

    assign w_accept  = frame_valid && (rx_data[63:32] == 32'd0);
    assign w_reject  = frame_valid && (rx_data[63:32] != 32'd0);
    assign w_consume = (r_state == COMMIT);
    assign w_link_ok = (r_watchdog != c_TIMEOUT);

    // The tick that brings the watchdog to the limit aborts everything in the
    // same cycle, including the strobe of the state currently being served.
    assign w_expire  = tick_10hz && !w_accept && (r_watchdog == c_TIMEOUT_M1);

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_strobe     = 4'b0000;
        case (r_state)
            IDLE: begin
                if (tick_10hz && r_pending_valid && w_link_ok) begin
                    w_next_state = COMMIT;
                end
            end
            COMMIT: begin
                w_next_state = S_PEDAL;
            end
            S_PEDAL: begin
                if (!check_busy) begin
                    w_strobe     = 4'b1000;
                    w_next_state = S_EXPR;
                end
            end
            S_EXPR: begin
                if (!check_busy) begin
                    w_strobe     = 4'b0100;
                    w_next_state = S_BPM;
                end
            end
            S_BPM: begin
                if (!check_busy) begin
                    w_strobe     = 4'b0010;
                    w_next_state = S_RR;
                end
            end
            S_RR: begin
                if (!check_busy) begin
                    w_strobe     = 4'b0001;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (w_expire) begin
            w_next_state = IDLE;
            w_strobe     = 4'b0000;
        end
    end

    // ------------------------------------------------------------------------
    // Pending frame and committed buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending       <= 32'd0;
            r_pending_valid <= 1'b0;
        end else if (w_expire) begin
            r_pending_valid <= 1'b0;
        end else if (w_accept) begin
            // A coincident commit reads the old value this cycle, so the new
            // frame simply replaces it and stays pending.
            r_pending       <= rx_data[31:0];
            r_pending_valid <= 1'b1;
        end else if (w_consume) begin
            r_pending_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_buffer <= 32'd0;
        end else if (w_expire) begin
            r_state_buffer <= 32'd0;
        end else if (w_consume) begin
            r_state_buffer <= r_pending;
        end
    end

    // ------------------------------------------------------------------------
    // Link watchdog, counted in ticks since the last accepted frame
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_watchdog <= c_TIMEOUT;
        end else if (w_accept) begin
            r_watchdog <= 4'd0;
        end else if (tick_10hz && (r_watchdog != c_TIMEOUT)) begin
            r_watchdog <= r_watchdog + 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating error statistics
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err_cnt <= 8'd0;
        end else if (w_reject && (r_frame_err_cnt != c_CNT_MAX)) begin
            r_frame_err_cnt <= r_frame_err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun_cnt <= 8'd0;
        end else if (w_accept && r_pending_valid && !w_consume
                     && (r_overrun_cnt != c_CNT_MAX)) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
    end

    assign state_buffer  = r_state_buffer;
    assign sample_strobe = w_strobe;
    assign link_ok       = w_link_ok;
    assign frame_err_cnt = r_frame_err_cnt;
    assign overrun_cnt   = r_overrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pmpd_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmpd_frame_scheduler
// Brief    : Scoreboard bench for pmpd_frame_scheduler strobe sequencing,
//            overrun/error counting, watchdog timeout and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmpd_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_valid = 1'b0;
    logic [63:0] rx_data = 64'd0;
    logic        tick_10hz = 1'b0;
    logic        check_busy = 1'b0;
    logic [31:0] state_buffer;
    logic [3:0]  sample_strobe;
    logic        link_ok;
    logic [7:0]  frame_err_cnt;
    logic [7:0]  overrun_cnt;

    pmpd_frame_scheduler #(.TIMEOUT_TICKS(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_valid   (frame_valid),
        .rx_data       (rx_data),
        .tick_10hz     (tick_10hz),
        .check_busy    (check_busy),
        .state_buffer  (state_buffer),
        .sample_strobe (sample_strobe),
        .link_ok       (link_ok),
        .frame_err_cnt (frame_err_cnt),
        .overrun_cnt   (overrun_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  stb;
        logic [31:0] sbuf;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Each call occupies one cycle with the given pulses; the next call clears them.
    task automatic drive(input logic fv, input logic [63:0] d, input logic tk);
        step();
        frame_valid = fv;
        rx_data     = d;
        tick_10hz   = tk;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 64'd0, 1'b0);
    endtask

    task automatic push_seq(input int t, input logic [31:0] d);
        sb.push_back('{t + 2, 4'b1000, d});
        sb.push_back('{t + 3, 4'b0100, d});
        sb.push_back('{t + 4, 4'b0010, d});
        sb.push_back('{t + 5, 4'b0001, d});
    endtask

    // Strobe monitor: every observed strobe is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && sample_strobe != 4'd0) begin
            exp_t e;
            chk("strobe_onehot", 64'($countones(sample_strobe)), 64'd1);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {60'd0, sample_strobe}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("strobe_bit", {60'd0, sample_strobe}, {60'd0, e.stb});
                chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
                chk("strobe_buf", {32'd0, state_buffer}, {32'd0, e.sbuf});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_buf", {32'd0, state_buffer}, 64'd0);
        chk("rst_strobe", {60'd0, sample_strobe}, 64'd0);
        chk("rst_link", {63'd0, link_ok}, 64'd0);
        chk("rst_err", {56'd0, frame_err_cnt}, 64'd0);
        chk("rst_ovr", {56'd0, overrun_cnt}, 64'd0);
        rst = 1'b0;
        idle(2);
        chk("link_down_before_frame", {63'd0, link_ok}, 64'd0);

        // Basic frame then tick
        drive(1'b1, 64'h0000_0000_4020_1050, 1'b0);
        idle(1);
        chk("link_up_after_frame", {63'd0, link_ok}, 64'd1);
        drive(1'b0, 64'd0, 1'b1);
        t = cyc;
        push_seq(t, 32'h4020_1050);
        idle(1);
        chk("buf_before_commit", {32'd0, state_buffer}, 64'd0);
        idle(7);

        // Rejected frame: counted, not committed
        drive(1'b1, {32'h0000_0001, 32'hDEAD_BEEF}, 1'b0);
        idle(1);
        chk("err_cnt_one", {56'd0, frame_err_cnt}, 64'd1);
        drive(1'b0, 64'd0, 1'b1);
        idle(8);
        chk("buf_after_reject", {32'd0, state_buffer}, 64'h4020_1050);

        // Two frames before one tick: overrun, second frame committed
        drive(1'b1, 64'h0000_0000_1122_3344, 1'b0);
        drive(1'b1, 64'h0000_0000_5566_7788, 1'b0);
        idle(1);
        chk("ovr_cnt_one", {56'd0, overrun_cnt}, 64'd1);
        drive(1'b0, 64'd0, 1'b1);
        t = cyc;
        push_seq(t, 32'h5566_7788);
        idle(8);

        // check_busy held for 3 cycles in S_EXPR
        drive(1'b1, 64'h0000_0000_0A0B_0C0D, 1'b0);
        idle(1);
        drive(1'b0, 64'd0, 1'b1);
        t = cyc;
        sb.push_back('{t + 2, 4'b1000, 32'h0A0B_0C0D});
        sb.push_back('{t + 6, 4'b0100, 32'h0A0B_0C0D});
        sb.push_back('{t + 7, 4'b0010, 32'h0A0B_0C0D});
        sb.push_back('{t + 8, 4'b0001, 32'h0A0B_0C0D});
        idle(3);
        check_busy = 1'b1;
        idle(2);
        idle(1);
        check_busy = 1'b0;
        idle(6);

        // Accept coinciding with commit: old value committed, new stays pending
        drive(1'b1, 64'h0000_0000_D0D0_D0D0, 1'b0);
        idle(1);
        drive(1'b0, 64'd0, 1'b1);
        t = cyc;
        push_seq(t, 32'hD0D0_D0D0);
        drive(1'b1, 64'h0000_0000_E0E0_E0E0, 1'b0);
        idle(7);
        chk("ovr_no_count_on_coincide", {56'd0, overrun_cnt}, 64'd1);
        drive(1'b0, 64'd0, 1'b1);
        t = cyc;
        push_seq(t, 32'hE0E0_E0E0);
        idle(8);

        // Fifth tick lands in S_BPM: abort, no strobes 2/1
        drive(1'b1, 64'h0000_0000_F1F2_F3F4, 1'b0);
        idle(1);
        drive(1'b0, 64'd0, 1'b1);
        t = cyc;
        sb.push_back('{t + 2, 4'b1000, 32'hF1F2_F3F4});
        sb.push_back('{t + 3, 4'b0100, 32'hF1F2_F3F4});
        for (int i = 0; i < 4; i++) drive(1'b0, 64'd0, 1'b1);
        idle(1);
        chk("timeout_link", {63'd0, link_ok}, 64'd0);
        chk("timeout_buf", {32'd0, state_buffer}, 64'd0);
        drive(1'b0, 64'd0, 1'b1);
        idle(8);

        // Frame and tick together while link down: frame wins, no start
        drive(1'b1, 64'h0000_0000_0600_0D00, 1'b1);
        idle(1);
        chk("accept_over_tick_link", {63'd0, link_ok}, 64'd1);
        idle(3);
        drive(1'b0, 64'd0, 1'b1);
        t = cyc;
        push_seq(t, 32'h0600_0D00);
        idle(8);

        // Asynchronous reset mid-sequence
        drive(1'b1, 64'h0000_0000_AAAA_5555, 1'b0);
        idle(1);
        drive(1'b0, 64'd0, 1'b1);
        t = cyc;
        sb.push_back('{t + 2, 4'b1000, 32'hAAAA_5555});
        idle(3);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_buf", {32'd0, state_buffer}, 64'd0);
        chk("async_rst_strobe", {60'd0, sample_strobe}, 64'd0);
        chk("async_rst_link", {63'd0, link_ok}, 64'd0);
        chk("async_rst_err", {56'd0, frame_err_cnt}, 64'd0);
        chk("async_rst_ovr", {56'd0, overrun_cnt}, 64'd0);
        step();
        rst = 1'b0;

        // Counter saturation
        for (int i = 0; i < 260; i++) drive(1'b1, {32'h8000_0000, 32'(i)}, 1'b0);
        idle(1);
        chk("err_cnt_sat", {56'd0, frame_err_cnt}, 64'd255);
        for (int i = 0; i < 260; i++) drive(1'b1, {32'd0, 32'(i)}, 1'b0);
        idle(1);
        chk("ovr_cnt_sat", {56'd0, overrun_cnt}, 64'd255);
        chk("err_cnt_hold", {56'd0, frame_err_cnt}, 64'd255);
        idle(4);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
